// File: rtl/wishbone_slave_mux_pkg.sv
// Shared types and default address map for the
// Wishbone single-master slave multiplexer.
package wishbone_slave_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERROR  = 2'd2
  } wb_state_e;

  localparam int LITEX_SLAVES = 5;

  localparam logic [31:0] ROM_BASE  = 32'h0000_0000;
  localparam logic [31:0] ROM_MASK  = 32'hFFFF_0000;
  localparam logic [31:0] SRAM_BASE = 32'h1000_0000;
  localparam logic [31:0] SRAM_MASK = 32'hFFFF_F000;
  localparam logic [31:0] RAM_BASE  = 32'h4000_0000;
  localparam logic [31:0] RAM_MASK  = 32'hFC00_0000;
  localparam logic [31:0] CSR_BASE  = 32'hF000_0000;
  localparam logic [31:0] CSR_MASK  = 32'hFFFE_0000;
  localparam logic [31:0] PLIC_BASE = 32'hF0C0_0000;
  localparam logic [31:0] PLIC_MASK = 32'hFFC0_0000;

  // Slave 0 sits in the least significant word.
  localparam logic [LITEX_SLAVES*32-1:0] LITEX_BASES = {
    PLIC_BASE, CSR_BASE, RAM_BASE, SRAM_BASE, ROM_BASE
  };

  localparam logic [LITEX_SLAVES*32-1:0] LITEX_MASKS = {
    PLIC_MASK, CSR_MASK, RAM_MASK, SRAM_MASK, ROM_MASK
  };

  // A disabled timeout still needs a one-bit counter.
  function automatic int cnt_width(input int t);
    return (t <= 0) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/wishbone_slave_mux_addr_decoder.sv
// Combinational base/mask window decoder.
// Lowest-index matching window wins.
module wishbone_addr_decoder #(
  parameter int NUM_SLAVES = 5,
  parameter int ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] bases,
  input  logic [NUM_SLAVES*ADDR_WIDTH-1:0] masks,
  output logic [NUM_SLAVES-1:0]            hit,
  output logic                             none
);

  // Scan high to low so the lowest hit overrides.
  always_comb begin
    hit  = '0;
    none = 1'b1;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if ((addr & masks[i*ADDR_WIDTH +: ADDR_WIDTH])
          == bases[i*ADDR_WIDTH +: ADDR_WIDTH]) begin
        hit    = '0;
        hit[i] = 1'b1;
        none   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/wishbone_slave_mux.sv
// Wishbone B4 classic 1:N interconnect with
// latched grant, unmapped-error and timeout.
module wishbone_slave_mux
  import wishbone_slave_mux_pkg::*;
#(
  parameter int NUM_SLAVES     = 5,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] BASE_ADDRS = LITEX_BASES,
  parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] ADDR_MASKS = LITEX_MASKS,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [ADDR_WIDTH-1:0]            m_ADR_I,
  input  logic [DATA_WIDTH-1:0]            m_DAT_I,
  output logic [DATA_WIDTH-1:0]            m_DAT_O,
  input  logic                             m_CYC_I,
  input  logic                             m_STB_I,
  input  logic                             m_WE_I,
  input  logic [DATA_WIDTH/8-1:0]          m_SEL_I,
  output logic                             m_ACK_O,
  output logic                             m_ERR_O,
  output logic [ADDR_WIDTH-1:0]            s_ADR_O,
  output logic [DATA_WIDTH-1:0]            s_DAT_O,
  output logic                             s_WE_O,
  output logic [DATA_WIDTH/8-1:0]          s_SEL_O,
  output logic [NUM_SLAVES-1:0]            s_CYC_O,
  output logic [NUM_SLAVES-1:0]            s_STB_O,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_DAT_I,
  input  logic [NUM_SLAVES-1:0]            s_ACK_I,
  output logic                             bus_error
);

  localparam int CW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  wb_state_e               state_q;
  logic [NUM_SLAVES-1:0]   grant_q;
  logic [CW-1:0]           cnt_q;
  logic [NUM_SLAVES-1:0]   dec_hit;
  logic                    dec_none;
  logic                    req;
  logic                    active;
  logic                    to_hit;
  logic                    ack;
  logic [DATA_WIDTH-1:0]   rd_data;

  wishbone_addr_decoder #(
    .NUM_SLAVES (NUM_SLAVES),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_dec (
    .addr  (m_ADR_I),
    .bases (BASE_ADDRS),
    .masks (ADDR_MASKS),
    .hit   (dec_hit),
    .none  (dec_none)
  );

  assign req    = m_CYC_I & m_STB_I;
  assign active = (state_q == ST_ACTIVE);
  assign to_hit = TO_EN && (cnt_q == TMAX);

  assign s_ADR_O = m_ADR_I;
  assign s_DAT_O = m_DAT_I;
  assign s_WE_O  = m_WE_I;
  assign s_SEL_O = m_SEL_I;

  assign m_ERR_O = (state_q == ST_ERROR);
  assign m_ACK_O = ack;

  // Read data of the granted slave.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (grant_q[i]) begin
        rd_data = rd_data | s_DAT_I[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Route strobes to the grant and pass ack/data back.
  always_comb begin
    s_CYC_O = '0;
    s_STB_O = '0;
    ack     = active & req & (|(grant_q & s_ACK_I));
    m_DAT_O = '0;
    if (active && !to_hit) begin
      s_CYC_O = grant_q & {NUM_SLAVES{m_CYC_I}};
      s_STB_O = grant_q & {NUM_SLAVES{m_STB_I}};
    end
    if (ack) begin
      m_DAT_O = rd_data;
    end
  end

  // Transfer FSM with grant, timeout counter and sticky error.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      cnt_q     <= '0;
      bus_error <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (req) begin
            if (dec_none) begin
              state_q   <= ST_ERROR;
              bus_error <= 1'b1;
            end else begin
              state_q <= ST_ACTIVE;
              grant_q <= dec_hit;
              cnt_q   <= '0;
            end
          end
        end
        ST_ACTIVE: begin
          if (ack || !req) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
          end else if (to_hit) begin
            state_q   <= ST_ERROR;
            grant_q   <= '0;
            bus_error <= 1'b1;
          end else if (cnt_q != TMAX) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_ERROR: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule
